// File: rtl/mc_ctrl_stall.sv
// Multicycle RV32I control FSM with memory request/ready wait states, an optional
// wait timeout, an illegal-instruction trap and a retired-instruction counter.
module mc_ctrl_stall #(
  parameter int unsigned BRANCH_EXT     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             Ltu,
  input  logic             mem_ready,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_JALR   = 4'd11;
  localparam logic [3:0] S_JALWB  = 4'd12;
  localparam logic [3:0] S_LUI    = 4'd13;
  localparam logic [3:0] S_TRAP   = 4'd14;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [2:0] IMM_I      = 3'b000;
  localparam logic [2:0] IMM_S      = 3'b001;
  localparam logic [2:0] IMM_B      = 3'b010;
  localparam logic [2:0] IMM_J      = 3'b011;
  localparam logic [2:0] IMM_U      = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic       wait_st;
  logic       limit_hit;
  logic       br_legal;
  logic       br_taken;
  logic       mem_req_c;
  logic       mem_write_c;
  logic       adr_src_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic       reg_write_c;
  logic [1:0] result_src_c;
  logic [1:0] alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [2:0] imm_src_c;
  logic [3:0] alu_ctl_c;

  // funct3 decode shared by register and immediate ALU ops
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub_sel,
                                         input logic sra_sel);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = sub_sel ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = sra_sel ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  // Branch legality and condition; funct3 010/011 are never branches
  always_comb begin
    br_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || ((BRANCH_EXT != 0) && funct3[2]);
    case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = ~Zero;
      3'b100:  br_taken = Lt;
      3'b101:  br_taken = ~Lt;
      3'b110:  br_taken = Ltu;
      3'b111:  br_taken = ~Ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Next state, strobes, wait counter, trap flags and retire counter
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    count_d      = count_q;
    wait_st      = 1'b0;
    wait_inc     = wait_cnt_q + WAIT_W'(1);
    limit_hit    = 1'b0;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RD2;
    imm_src_c    = IMM_I;
    alu_ctl_c    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURES;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else begin
          wait_st = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = br_legal ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = op[5] ? IMM_S : IMM_I;
        state_d     = op[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else           wait_st = 1'b1;
      end
      S_MEMWB: begin
        result_src_c = RES_DATA;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else           wait_st = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_RD2;
        alu_ctl_c   = alu_dec(funct3, funct7b5, funct7b5);
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_c = SRCA_RD1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_I;
        alu_ctl_c   = alu_dec(funct3, 1'b0, funct7b5);
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src_c = RES_ALUOUT;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c  = SRCA_RD1;
        alu_src_b_c  = SRCB_RD2;
        alu_ctl_c    = ALU_SUB;
        result_src_c = RES_ALUOUT;
        pc_write_c   = br_taken;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target latched in DECODE while the ALU forms the link address
        result_src_c = RES_ALUOUT;
        pc_write_c   = 1'b1;
        alu_src_a_c  = SRCA_OLDPC;
        alu_src_b_c  = SRCB_FOUR;
        state_d      = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a_c  = SRCA_RD1;
        alu_src_b_c  = SRCB_IMM;
        imm_src_c    = IMM_I;
        result_src_c = RES_ALURES;
        pc_write_c   = 1'b1;
        state_d      = S_JALWB;
      end
      S_JALWB: begin
        alu_src_a_c  = SRCA_OLDPC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALURES;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_LUI: begin
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_U;
        alu_ctl_c   = ALU_PASSB;
        state_d     = S_ALUWB;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Last allowed wait cycle without ready aborts the access with no strobes
    if (wait_st) begin
      limit_hit = (TIMEOUT_CYCLES != 0) && (wait_inc == WAIT_W'(TIMEOUT_CYCLES));
      if (limit_hit) begin
        state_d      = S_TRAP;
        timeout_d    = 1'b1;
        mem_req_c    = 1'b0;
        mem_write_c  = 1'b0;
        adr_src_c    = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RD2;
        imm_src_c    = IMM_I;
        alu_ctl_c    = ALU_ADD;
      end else if (TIMEOUT_CYCLES != 0) begin
        wait_cnt_d = wait_inc;
      end
    end

    if (state_d == S_TRAP) illegal_d = 1'b1;
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      count_q    <= count_d;
    end
  end

  // Strobes are held low for as long as reset is asserted
  assign MemReq      = rst & mem_req_c;
  assign MemWrite    = rst & mem_write_c;
  assign AdrSrc      = rst & adr_src_c;
  assign IRWrite     = rst & ir_write_c;
  assign PCWrite     = rst & pc_write_c;
  assign RegWrite    = rst & reg_write_c;
  assign ResultSrc   = rst ? result_src_c : 2'b00;
  assign ALUSrcA     = rst ? alu_src_a_c : 2'b00;
  assign ALUSrcB     = rst ? alu_src_b_c : 2'b00;
  assign ImmSrc      = rst ? imm_src_c : 3'b000;
  assign ALUControl  = rst ? alu_ctl_c : 4'b0000;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_ctrl_stall.sv
// Scoreboard bench for mc_ctrl_stall: two instances (extended branches with a
// 5-cycle timeout and 4-bit counter, and base branches with no timeout).
module tb_mc_ctrl_stall;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       Lt = 1'b0;
  logic       Ltu = 1'b0;
  logic       mem_ready = 1'b0;

  logic d0_MemReq, d0_MemWrite, d0_AdrSrc, d0_IRWrite, d0_PCWrite, d0_RegWrite;
  logic [1:0] d0_ResultSrc, d0_ALUSrcA, d0_ALUSrcB;
  logic [2:0] d0_ImmSrc;
  logic [3:0] d0_ALUControl;
  logic d0_illegal, d0_timeout;
  logic [3:0] d0_cnt;

  logic d1_MemReq, d1_MemWrite, d1_AdrSrc, d1_IRWrite, d1_PCWrite, d1_RegWrite;
  logic [1:0] d1_ResultSrc, d1_ALUSrcA, d1_ALUSrcB;
  logic [2:0] d1_ImmSrc;
  logic [3:0] d1_ALUControl;
  logic d1_illegal, d1_timeout;
  logic [31:0] d1_cnt;

  mc_ctrl_stall #(.BRANCH_EXT(1), .TIMEOUT_CYCLES(5), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .MemReq(d0_MemReq), .MemWrite(d0_MemWrite), .AdrSrc(d0_AdrSrc), .IRWrite(d0_IRWrite),
    .PCWrite(d0_PCWrite), .RegWrite(d0_RegWrite), .ResultSrc(d0_ResultSrc),
    .ALUSrcA(d0_ALUSrcA), .ALUSrcB(d0_ALUSrcB), .ImmSrc(d0_ImmSrc),
    .ALUControl(d0_ALUControl), .illegal(d0_illegal), .timeout(d0_timeout),
    .instr_count(d0_cnt));

  mc_ctrl_stall #(.BRANCH_EXT(0), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
    .MemReq(d1_MemReq), .MemWrite(d1_MemWrite), .AdrSrc(d1_AdrSrc), .IRWrite(d1_IRWrite),
    .PCWrite(d1_PCWrite), .RegWrite(d1_RegWrite), .ResultSrc(d1_ResultSrc),
    .ALUSrcA(d1_ALUSrcA), .ALUSrcB(d1_ALUSrcB), .ImmSrc(d1_ImmSrc),
    .ALUControl(d1_ALUControl), .illegal(d1_illegal), .timeout(d1_timeout),
    .instr_count(d1_cnt));

  always #5 clk = ~clk;

  // {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl}
  logic [18:0] s0, s1;
  assign s0 = {d0_MemReq, d0_MemWrite, d0_AdrSrc, d0_IRWrite, d0_PCWrite, d0_RegWrite,
               d0_ResultSrc, d0_ALUSrcA, d0_ALUSrcB, d0_ImmSrc, d0_ALUControl};
  assign s1 = {d1_MemReq, d1_MemWrite, d1_AdrSrc, d1_IRWrite, d1_PCWrite, d1_RegWrite,
               d1_ResultSrc, d1_ALUSrcA, d1_ALUSrcB, d1_ImmSrc, d1_ALUControl};

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_JALR = 7'b1100111;

  int vectors = 0;
  int miscompares = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp1_q[$];
  logic        rdy_q[$];
  logic [3:0]  cnt_q[$];
  logic [31:0] cnt1_q[$];

  logic [18:0] v_zero, v_f_rdy, v_f_wait, v_dec_b, v_madr_i, v_madr_s, v_mrd, v_mwb, v_mwr;
  logic [18:0] v_exr_add, v_aluwb, v_br_t, v_br_n, v_jalr, v_jalwb;

  function automatic logic [18:0] pk(input logic mreq, input logic mwr, input logic adr,
                                     input logic irw, input logic pcw, input logic rgw,
                                     input logic [1:0] res, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] imm,
                                     input logic [3:0] alu);
    return {mreq, mwr, adr, irw, pcw, rgw, res, sa, sb, imm, alu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; mem_ready = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    exp_q.delete(); exp1_q.delete(); rdy_q.delete();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (s0 !== 19'd0) begin miscompares++; $display("FAIL reset_strobes0: got %b want 0", s0); end
    vectors++;
    if (s1 !== 19'd0) begin miscompares++; $display("FAIL reset_strobes1: got %b want 0", s1); end
    vectors++;
    if ({d0_cnt, d0_illegal, d0_timeout} !== 6'd0) begin
      miscompares++; $display("FAIL reset_flags: got cnt=%0d ill=%b to=%b want 0", d0_cnt, d0_illegal, d0_timeout);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (s0 !== v_f_rdy) begin miscompares++; $display("FAIL reset_fetch: got %b want %b", s0, v_f_rdy); end
    tick();
  endtask

  task automatic test_add();
    int cyc = 0;
    do_reset();
    op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0;
    exp_q = {v_f_rdy, v_dec_b, v_exr_add, v_aluwb};
    rdy_q = {1'b1, 1'b1, 1'b1, 1'b1};
    while (exp_q.size() != 0) begin
      logic [18:0] e;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL add cyc%0d: got %b want %b", cyc, s0, e); end
      cyc++;
      tick();
    end
    vectors++;
    if (d0_cnt !== 4'd1) begin miscompares++; $display("FAIL add_count: got %0d want 1", d0_cnt); end
  endtask

  task automatic test_load_wait();
    int cyc = 0;
    do_reset();
    op = OP_LOAD; funct3 = 3'b010;
    exp_q = {v_f_rdy, v_dec_b, v_madr_i, v_mrd, v_mrd, v_mrd, v_mrd, v_mwb};
    rdy_q = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    while (exp_q.size() != 0) begin
      logic [18:0] e;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL lw cyc%0d: got %b want %b", cyc, s0, e); end
      cyc++;
      tick();
    end
    vectors++;
    if (d0_cnt !== 4'd1) begin miscompares++; $display("FAIL lw_count: got %0d want 1", d0_cnt); end
  endtask

  task automatic test_branch();
    int cyc = 0;
    do_reset();
    op = OP_BR;
    for (int b = 0; b < 2; b++) begin
      funct3 = (b == 0) ? 3'b100 : 3'b111;
      Lt = (b == 0); Ltu = (b == 1);
      exp_q = {v_f_rdy, v_dec_b, (b == 0) ? v_br_t : v_br_n};
      rdy_q = {1'b1, 1'b0, 1'b0};
      while (exp_q.size() != 0) begin
        logic [18:0] e;
        mem_ready = rdy_q.pop_front();
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (s0 !== e) begin miscompares++; $display("FAIL branch%0d cyc%0d: got %b want %b", b, cyc, s0, e); end
        cyc++;
        tick();
      end
    end
    vectors++;
    if (d0_cnt !== 4'd2) begin miscompares++; $display("FAIL branch_count: got %0d want 2", d0_cnt); end
  endtask

  task automatic test_illegal_branch();
    int cyc = 0;
    do_reset();
    op = OP_BR; funct3 = 3'b010;
    exp_q = {v_f_rdy, v_dec_b, v_zero, v_zero};
    rdy_q = {1'b1, 1'b1, 1'b1, 1'b1};
    while (exp_q.size() != 0) begin
      logic [18:0] e;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL br010 cyc%0d: got %b want %b", cyc, s0, e); end
      cyc++;
      tick();
    end
    vectors++;
    if ({d0_illegal, d0_cnt} !== 5'b1_0000) begin
      miscompares++; $display("FAIL br010_flags: got ill=%b cnt=%0d want ill=1 cnt=0", d0_illegal, d0_cnt);
    end
    // blt is legal only on the extended instance
    do_reset();
    cyc = 0;
    op = OP_BR; funct3 = 3'b100; Lt = 1'b1;
    exp_q  = {v_f_rdy, v_dec_b, v_br_t, v_f_rdy};
    exp1_q = {v_f_rdy, v_dec_b, v_zero, v_zero};
    rdy_q  = {1'b1, 1'b0, 1'b0, 1'b1};
    while (exp_q.size() != 0) begin
      logic [18:0] e, e1;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL blt_ext1 cyc%0d: got %b want %b", cyc, s0, e); end
      vectors++;
      if (s1 !== e1) begin miscompares++; $display("FAIL blt_ext0 cyc%0d: got %b want %b", cyc, s1, e1); end
      cyc++;
      tick();
    end
    vectors++;
    if ({d1_illegal, d1_cnt} !== {1'b1, 32'd0}) begin
      miscompares++; $display("FAIL blt_ext0_flags: got ill=%b cnt=%0d want ill=1 cnt=0", d1_illegal, d1_cnt);
    end
  endtask

  task automatic test_illegal_op();
    int cyc = 0;
    do_reset();
    op = OP_R; funct3 = 3'b000;
    mem_ready = 1'b1;
    repeat (4) tick();
    op = 7'b0000000;
    exp_q = {v_f_rdy, v_dec_b, v_zero, v_zero, v_zero, v_zero};
    rdy_q = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    while (exp_q.size() != 0) begin
      logic [18:0] e;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL op0 cyc%0d: got %b want %b", cyc, s0, e); end
      cyc++;
      tick();
    end
    vectors++;
    if ({d0_illegal, d0_timeout, d0_cnt} !== 6'b10_0001) begin
      miscompares++;
      $display("FAIL op0_flags: got ill=%b to=%b cnt=%0d want ill=1 to=0 cnt=1", d0_illegal, d0_timeout, d0_cnt);
    end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    do_reset();
    exp_q  = {v_f_wait, v_f_wait, v_f_wait, v_f_wait, v_zero, v_zero, v_zero};
    exp1_q = {v_f_wait, v_f_wait, v_f_wait, v_f_wait, v_f_wait, v_f_wait, v_f_wait};
    rdy_q  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    while (exp_q.size() != 0) begin
      logic [18:0] e, e1;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL tmo cyc%0d: got %b want %b", cyc, s0, e); end
      vectors++;
      if (s1 !== e1) begin miscompares++; $display("FAIL notmo cyc%0d: got %b want %b", cyc, s1, e1); end
      cyc++;
      tick();
    end
    vectors++;
    if ({d0_timeout, d0_illegal, d1_timeout, d1_illegal} !== 4'b1100) begin
      miscompares++;
      $display("FAIL tmo_flags: got to0=%b ill0=%b to1=%b ill1=%b want 1100", d0_timeout, d0_illegal, d1_timeout, d1_illegal);
    end
  endtask

  task automatic test_ready_at_limit();
    int cyc = 0;
    do_reset();
    op = OP_R;
    exp_q = {v_f_wait, v_f_wait, v_f_wait, v_f_wait, v_f_rdy, v_dec_b};
    rdy_q = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    while (exp_q.size() != 0) begin
      logic [18:0] e;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL rdy_limit cyc%0d: got %b want %b", cyc, s0, e); end
      cyc++;
      tick();
    end
    vectors++;
    if ({d0_timeout, d0_illegal} !== 2'b00) begin
      miscompares++; $display("FAIL rdy_limit_flags: got to=%b ill=%b want 0 0", d0_timeout, d0_illegal);
    end
  endtask

  task automatic test_jalr();
    int cyc = 0;
    do_reset();
    op = OP_JALR; funct3 = 3'b000;
    exp_q = {v_f_rdy, v_dec_b, v_jalr, v_jalwb};
    rdy_q = {1'b1, 1'b0, 1'b0, 1'b0};
    while (exp_q.size() != 0) begin
      logic [18:0] e;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL jalr cyc%0d: got %b want %b", cyc, s0, e); end
      cyc++;
      tick();
    end
    vectors++;
    if (d0_cnt !== 4'd1) begin miscompares++; $display("FAIL jalr_count: got %0d want 1", d0_cnt); end
  endtask

  task automatic test_reset_mid_store();
    int cyc = 0;
    do_reset();
    op = OP_R; funct3 = 3'b000;
    mem_ready = 1'b1;
    repeat (4) tick();
    op = OP_STORE; funct3 = 3'b010;
    exp_q = {v_f_rdy, v_dec_b, v_madr_s, v_mwr};
    rdy_q = {1'b1, 1'b0, 1'b0, 1'b0};
    while (exp_q.size() != 0) begin
      logic [18:0] e;
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (s0 !== e) begin miscompares++; $display("FAIL sw cyc%0d: got %b want %b", cyc, s0, e); end
      cyc++;
      if (exp_q.size() != 0) tick();
    end
    vectors++;
    if (d0_cnt !== 4'd1) begin miscompares++; $display("FAIL sw_count_pre: got %0d want 1", d0_cnt); end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({d0_MemReq, d0_MemWrite} !== 2'b00) begin
      miscompares++; $display("FAIL sw_async_drop: got req=%b wr=%b want 0 0", d0_MemReq, d0_MemWrite);
    end
    vectors++;
    if (d0_cnt !== 4'd0) begin miscompares++; $display("FAIL sw_count_rst: got %0d want 0", d0_cnt); end
    tick();
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (s0 !== v_f_rdy) begin miscompares++; $display("FAIL sw_refetch: got %b want %b", s0, v_f_rdy); end
    tick();
  endtask

  task automatic test_count_wrap();
    logic [3:0]  m0 = 4'd0;
    logic [31:0] m1 = 32'd0;
    do_reset();
    op = OP_R; funct3 = 3'b000; mem_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      m0 = m0 + 4'd1;
      m1 = m1 + 32'd1;
      cnt_q.push_back(m0);
      cnt1_q.push_back(m1);
      repeat (4) tick();
      begin
        logic [3:0]  e0;
        logic [31:0] e1;
        e0 = cnt_q.pop_front();
        e1 = cnt1_q.pop_front();
        vectors++;
        if (d0_cnt !== e0) begin miscompares++; $display("FAIL wrap4 retire%0d: got %0d want %0d", k, d0_cnt, e0); end
        vectors++;
        if (d1_cnt !== e1) begin miscompares++; $display("FAIL cnt32 retire%0d: got %0d want %0d", k, d1_cnt, e1); end
      end
    end
  endtask

  initial begin
    v_zero    = 19'd0;
    v_f_rdy   = pk(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0);
    v_f_wait  = pk(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 4'h0);
    v_dec_b   = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b010, 4'h0);
    v_madr_i  = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 4'h0);
    v_madr_s  = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b001, 4'h0);
    v_mrd     = pk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
    v_mwb     = pk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 4'h0);
    v_mwr     = pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
    v_exr_add = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h0);
    v_aluwb   = pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 4'h0);
    v_br_t    = pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h1);
    v_br_n    = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 4'h1);
    v_jalr    = pk(0, 0, 0, 0, 1, 0, 2'b10, 2'b10, 2'b01, 3'b000, 4'h0);
    v_jalwb   = pk(0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 3'b000, 4'h0);

    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_illegal_branch();
    test_illegal_op();
    test_timeout();
    test_ready_at_limit();
    test_jalr();
    test_reset_mid_store();
    test_count_wrap();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
